// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 load, per-round C/D rotation, PC-2 output.
// Encrypt walks K1..K16 with left shifts; decrypt walks K16..K1 with right shifts.
module des_key_schedule (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        clear,
  input  logic        key_ready,
  output logic [47:0] round_key,
  output logic        key_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [27:0] c_q, d_q;
  logic [3:0]  idx_q;
  logic        mode_q;
  logic        done_q;
  logic [55:0] pc1_key;
  logic [55:0] cd;
  logic [4:0]  rnd;
  logic        one;
  logic        accept;
  logic        last;

  // DES numbers bits from 1 at the MSB, hence the 64-n / 56-n mapping.
  always_comb begin
    pc1_key = '0;
    for (int j = 0; j < 56; j++)
      pc1_key[55-j] = key_in[64-PC1[j]];
  end

  assign cd = {c_q, d_q};

  always_comb begin
    round_key = '0;
    for (int j = 0; j < 48; j++)
      round_key[47-j] = cd[56-PC2[j]];
  end

  assign accept = (state == RUN) && key_ready;
  assign last   = mode_q ? (idx_q == 4'd0) : (idx_q == 4'd15);

  // Encrypt shifts for the next round, decrypt undoes the round just emitted.
  assign rnd = mode_q ? ({1'b0, idx_q} + 5'd1) : ({1'b0, idx_q} + 5'd2);
  assign one = (rnd == 5'd1) || (rnd == 5'd2) ||
               (rnd == 5'd9) || (rnd == 5'd16);

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic s1);
    return s1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic s1);
    return s1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (accept && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c_q    <= '0;
      d_q    <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        done_q <= 1'b0;
      end else if (state == IDLE && start) begin
        mode_q <= decrypt;
        if (decrypt) begin
          c_q   <= pc1_key[55:28];
          d_q   <= pc1_key[27:0];
          idx_q <= 4'd15;
        end else begin
          c_q   <= rotl(pc1_key[55:28], 1'b1);
          d_q   <= rotl(pc1_key[27:0], 1'b1);
          idx_q <= 4'd0;
        end
      end else if (accept) begin
        if (last) begin
          done_q <= 1'b1;
        end else if (mode_q) begin
          c_q   <= rotr(c_q, one);
          d_q   <= rotr(d_q, one);
          idx_q <= idx_q - 4'd1;
        end else begin
          c_q   <= rotl(c_q, one);
          d_q   <= rotl(d_q, one);
          idx_q <= idx_q + 4'd1;
        end
      end
    end
  end

  assign key_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule
